// File: rtl/shift_pkg.sv
// Shared definitions for the multi-cycle shift unit: op codes, FSM states
// and the counter-width helper.
package shift_pkg;

  localparam logic [1:0] OP_LSL = 2'b00;
  localparam logic [1:0] OP_LSR = 2'b01;
  localparam logic [1:0] OP_ASR = 2'b10;
  localparam logic [1:0] OP_ROR = 2'b11;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SHIFT = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;

  // Ceiling log2, used to size counters that must hold their maximum value.
  function automatic int clog2(input int v);
    return $clog2(v);
  endfunction

endpackage

// File: rtl/shift_step.sv
// One cycle of shifting: moves data by k (0..STEP) positions and reports the
// last bit that left the register.
module shift_step
  import shift_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int STEP  = 1,
  localparam int KW   = clog2(STEP) + 1
) (
  input  logic [WIDTH-1:0] data,
  input  logic [KW-1:0]    k,
  input  logic [1:0]       op,
  input  logic             fill,
  output logic [WIDTH-1:0] shifted,
  output logic             out_bit
);

  // Cascade of STEP single-bit stages, each enabled while its index is below k.
  always_comb begin
    shifted = data;
    out_bit = 1'b0;
    for (int i = 0; i < STEP; i++) begin
      if (KW'(i) < k) begin
        unique case (op)
          OP_LSL: begin
            out_bit = shifted[WIDTH-1];
            shifted = {shifted[WIDTH-2:0], 1'b0};
          end
          OP_LSR: begin
            out_bit = shifted[0];
            shifted = {1'b0, shifted[WIDTH-1:1]};
          end
          OP_ASR: begin
            out_bit = shifted[0];
            shifted = {fill, shifted[WIDTH-1:1]};
          end
          default: begin
            out_bit = shifted[0];
            shifted = {shifted[0], shifted[WIDTH-1:1]};
          end
        endcase
      end
    end
  end

endmodule

// File: rtl/shift_unit.sv
// Multi-cycle shifter with start/done handshake. Shifts up to STEP bits per
// cycle; result and carry are registered and held until the next start.
module shift_unit
  import shift_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int STEP  = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] value,
  input  logic [WIDTH-1:0] amount,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             carry
);

  localparam int CW = clog2(WIDTH) + 1;
  localparam int KW = clog2(STEP) + 1;
  localparam logic [WIDTH-1:0] W_VAL = WIDTH'(WIDTH);

  logic [1:0]       state;
  logic [1:0]       op_q;
  logic             sign_q;
  logic [CW-1:0]    remaining;
  logic [CW-1:0]    n;
  logic [KW-1:0]    k;
  logic [WIDTH-1:0] step_data;
  logic             step_bit;
  logic             accept;

  assign busy   = (state == SHIFT);
  assign done   = (state == DONE);
  // DONE accepts a new start just like IDLE, so back-to-back ops have no bubble.
  assign accept = start && (state != SHIFT);

  // Effective amount: plain shifts saturate at WIDTH, rotate wraps modulo WIDTH.
  always_comb begin
    n = '0;
    if (op == OP_ROR) n = CW'(amount % W_VAL);
    else if (amount >= W_VAL) n = CW'(WIDTH);
    else n = CW'(amount);
  end

  // Bits moved this cycle: min(STEP, remaining).
  always_comb begin
    k = '0;
    if (remaining > CW'(STEP)) k = KW'(STEP);
    else k = KW'(remaining);
  end

  shift_step #(.WIDTH(WIDTH), .STEP(STEP)) u_step (
    .data    (result),
    .k       (k),
    .op      (op_q),
    .fill    (sign_q),
    .shifted (step_data),
    .out_bit (step_bit)
  );

  // FSM, amount counter and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      op_q      <= OP_LSL;
      sign_q    <= 1'b0;
      remaining <= '0;
      result    <= '0;
      carry     <= 1'b0;
    end else if (accept) begin
      result    <= value;
      op_q      <= op;
      sign_q    <= value[WIDTH-1];
      carry     <= 1'b0;
      remaining <= n;
      state     <= (n == '0) ? DONE : SHIFT;
    end else begin
      unique case (state)
        SHIFT: begin
          result    <= step_data;
          carry     <= step_bit;
          remaining <= remaining - CW'(k);
          if (remaining == CW'(k)) state <= DONE;
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
